// File: rtl/sub16_serial_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM state encoding
// and default operand/slice widths.
package sub16_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 16;
    localparam int SLICE_DEF = 4;

endpackage

// File: rtl/sub16_serial_sub_slice.sv
// One SLICE-bit ripple of full-adder cells. The b operand arrives already
// complemented, so a + bn_i + cin_i yields one slice of a - b.
module sub16_serial_sub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] bn_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o
);

    logic [SLICE:0] cy;

    // Ripple the carry through SLICE full-adder cells.
    always_comb begin
        cy    = '0;
        sum_o = '0;
        cy[0] = cin_i;
        for (int i = 0; i < SLICE; i++) begin
            sum_o[i]  = a_i[i] ^ bn_i[i] ^ cy[i];
            cy[i+1]   = (a_i[i] & bn_i[i]) | (cy[i] & (a_i[i] ^ bn_i[i]));
        end
        cout_o = cy[SLICE];
    end

endmodule

// File: rtl/sub16_serial.sv
// Nibble-serial subtractor z = x - y, computed as x + ~y + 1 one slice per
// clock, with registered sign/zero/borrow/parity/overflow flags and
// valid/ready handshakes on both sides.
module sub16_serial
    import sub16_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             borrow,
    output logic             parity,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

    state_e           state_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] yn_q;
    logic [WIDTH-1:0] z_q;
    logic [WIDTH-1:0] z_d;
    logic             sign_q, zero_q, borrow_q, parity_q, overflow_q;
    logic             out_valid_q;

    logic [SLICE-1:0] x_s;
    logic [SLICE-1:0] yn_s;
    logic [SLICE-1:0] sum_s;
    logic             carry_d;

    // Select the operand slices addressed by the current index.
    always_comb begin
        x_s  = x_q[idx_q*SLICE +: SLICE];
        yn_s = yn_q[idx_q*SLICE +: SLICE];
    end

    sub16_serial_sub_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i    (x_s),
        .bn_i   (yn_s),
        .cin_i  (carry_q),
        .sum_o  (sum_s),
        .cout_o (carry_d)
    );

    // Insert the freshly computed slice into the result word.
    always_comb begin
        z_d = z_q;
        z_d[idx_q*SLICE +: SLICE] = sum_s;
    end

    // Operands are accepted when idle, or in DONE while the result is being consumed.
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);

    // FSM, datapath registers and flags; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            x_q         <= '0;
            yn_q        <= '0;
            z_q         <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            borrow_q    <= 1'b0;
            parity_q    <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q     <= x;
                        yn_q    <= ~y;
                        carry_q <= 1'b1;
                        idx_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    z_q     <= z_d;
                    carry_q <= carry_d;
                    idx_q   <= idx_q + IDXW'(1);
                    if (idx_q == IDX_LAST) begin
                        borrow_q    <= ~carry_d;
                        sign_q      <= z_d[WIDTH-1];
                        zero_q      <= (z_d == '0);
                        parity_q    <= ~^z_d;
                        overflow_q  <= (x_q[WIDTH-1] & yn_q[WIDTH-1] & ~z_d[WIDTH-1]) |
                                       (~x_q[WIDTH-1] & ~yn_q[WIDTH-1] & z_d[WIDTH-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            x_q     <= x;
                            yn_q    <= ~y;
                            carry_q <= 1'b1;
                            idx_q   <= '0;
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign sign      = sign_q;
    assign zero      = zero_q;
    assign borrow    = borrow_q;
    assign parity    = parity_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sub16_serial.sv
// Self-checking bench for sub16_serial: scoreboard of expected results
// built from an arithmetic reference model, one task per scenario.
module tb_sub16_serial;

    localparam int W = 16;
    localparam int NSL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  z;
    logic          sign, zero, borrow, parity, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // packed result: {z, sign, zero, borrow, parity, overflow}
    logic [W+4:0] sb[$];

    sub16_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .sign      (sign),
        .zero      (zero),
        .borrow    (borrow),
        .parity    (parity),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W+4:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        logic         ov;
        d  = a - b;
        ov = (a[W-1] & ~b[W-1] & ~d[W-1]) | (~a[W-1] & b[W-1] & d[W-1]);
        return {d, d[W-1], (d == '0), (a < b), ~^d, ov};
    endfunction

    function automatic logic [W+4:0] observed();
        return {z, sign, zero, borrow, parity, overflow};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accept edge and record the expected result.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        x = a;
        y = b;
        in_valid = 1'b1;
        sb.push_back(model(a, b));
        tick();
        in_valid = 1'b0;
        x = $urandom;
        y = $urandom;
    endtask

    // Count cycles from the accept edge until out_valid rises (-1 on timeout).
    task automatic wait_out(output int cyc);
        int cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        cyc = out_valid ? cnt : -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (observed() !== '0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", observed()); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_vectors();
        logic [W-1:0] xs[6] = '{16'h0005, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
        logic [W-1:0] ys[6] = '{16'h0003, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h8000};
        int cyc;
        logic [W+4:0] exp;
        for (int i = 0; i < 14; i++) begin
            logic [W-1:0] a, b;
            if (i < 6) begin a = xs[i]; b = ys[i]; end
            else begin a = W'($urandom); b = W'($urandom); end
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL vec%0d_in_ready got=%b exp=1", i, in_ready); end
            send(a, b);
            wait_out(cyc);
            n_checks++;
            if (cyc !== NSL) begin n_fail++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, cyc, NSL); end
            exp = sb.pop_front();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL vec%0d x=%h y=%h got={z,s,zr,b,p,ov}=%h exp=%h", i, a, b, observed(), exp);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_release got out_valid=%b in_ready=%b exp 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_hold();
        int cyc;
        logic [W+4:0] exp;
        send(16'h1234, 16'h1234);
        wait_out(cyc);
        exp = sb.pop_front();
        n_checks++;
        if (cyc !== NSL) begin n_fail++; $display("FAIL hold_latency got=%0d exp=%0d", cyc, NSL); end
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            x = W'($urandom);
            y = W'($urandom);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== exp) begin
                n_fail++;
                $display("FAIL hold_cycle%0d got ov=%b ir=%b res=%h exp 1/0/%h", k, out_valid, in_ready, observed(), exp);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [W+4:0] exp;
        send(16'h00F0, 16'h0F00);
        wait_out(cyc);
        exp = sb.pop_front();
        n_checks++;
        if (observed() !== exp) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", observed(), exp); end
        for (int j = 0; j < 3; j++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            out_ready = 1'b1;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_in_ready got=%b exp=1", j, in_ready); end
            send(a, b);
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b%0d_run got ov=%b ir=%b exp 0/0", j, out_valid, in_ready);
            end
            wait_out(cyc);
            n_checks++;
            if (cyc !== NSL) begin n_fail++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", j, cyc, NSL); end
            exp = sb.pop_front();
            n_checks++;
            if (observed() !== exp) begin n_fail++; $display("FAIL b2b%0d_result got=%h exp=%h", j, observed(), exp); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int cyc;
        logic [W+4:0] exp;
        send(16'hFFFF, 16'h0001);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        n_checks++;
        if (out_valid !== 1'b0 || observed() !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset got ov=%b res=%h exp 0/0", out_valid, observed());
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_idle got ir=%b ov=%b exp 1/0", in_ready, out_valid);
        end
        send(16'h4000, 16'hC000);
        wait_out(cyc);
        exp = sb.pop_front();
        n_checks++;
        if (cyc !== NSL || observed() !== exp) begin
            n_fail++;
            $display("FAIL midrun_after got lat=%0d res=%h exp %0d/%h", cyc, observed(), NSL, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_back_to_back();
        test_reset_midrun();
        n_checks++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
